// File: rtl/pyramid_scale_sequencer_if.sv
// Bus bundle between the pyramid sequencer, frame memory and the 1/2 scaler.
// master: sequencer side; slave: memory + scaler side.
interface pyramid_scale_sequencer_if #(
    parameter int LUMA_BITS  = 8,
    parameter int COORD_BITS = 16,
    parameter int ADDR_BITS  = 20
) ();
    logic                  mem_rd_en;
    logic [ADDR_BITS-1:0]  mem_rd_addr;
    logic [LUMA_BITS-1:0]  mem_rd_data;
    logic                  mem_wr_en;
    logic [ADDR_BITS-1:0]  mem_wr_addr;
    logic [LUMA_BITS-1:0]  mem_wr_data;
    logic                  sc_reset;
    logic [COORD_BITS-1:0] sc_width;
    logic [LUMA_BITS-1:0]  sc_in_pixel;
    logic                  sc_in_valid;
    logic [COORD_BITS-1:0] sc_in_x;
    logic [COORD_BITS-1:0] sc_in_y;
    logic [LUMA_BITS-1:0]  sc_out_pixel;
    logic                  sc_out_valid;
    logic [COORD_BITS-1:0] sc_out_x;
    logic [COORD_BITS-1:0] sc_out_y;

    modport master (
        output mem_rd_en, mem_rd_addr, input mem_rd_data,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output sc_reset, sc_width, sc_in_pixel, sc_in_valid,
        output sc_in_x, sc_in_y,
        input  sc_out_pixel, sc_out_valid, sc_out_x, sc_out_y
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, output mem_rd_data,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  sc_reset, sc_width, sc_in_pixel, sc_in_valid,
        input  sc_in_x, sc_in_y,
        output sc_out_pixel, sc_out_valid, sc_out_x, sc_out_y
    );
endinterface

// File: rtl/pyramid_scale_sequencer.sv
// Image pyramid builder: repeatedly streams a level through the 1/2 scaler
// and writes the result back behind it in frame memory.
// Ports: clk, reset (async, active-low), start/src_base/src_width/src_height
// control, busy/done/error/levels_done status, bus (memory + scaler).
// Optional macro PYRAMID_PERF_CNT_EN adds perf_cycles/perf_stream_cycles.
module pyramid_scale_sequencer #(
    parameter int LUMA_BITS     = 8,
    parameter int COORD_BITS    = 16,
    parameter int ADDR_BITS     = 20,
    parameter int MAX_LEVELS    = 4,
    parameter int ROW_GAP       = 6,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  src_base,
    input  logic [COORD_BITS-1:0] src_width,
    input  logic [COORD_BITS-1:0] src_height,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            levels_done,
`ifdef PYRAMID_PERF_CNT_EN
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_stream_cycles,
`endif
    pyramid_scale_sequencer_if.master bus
);
    localparam int CW  = COORD_BITS;
    localparam int AW  = ADDR_BITS;
    localparam int WCW = 2 * COORD_BITS;
    localparam int GW  = $clog2(ROW_GAP + 1);
    localparam int TW  = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SC_RST, STREAM, GAP, DRAIN, NEXT, DONE
    } state_t;

    state_t         state;
    logic [AW-1:0]  cur_base, dst_base, row_addr, rd_addr;
    logic [CW-1:0]  cur_w, cur_h, x, y, rd_x, rd_y;
    logic [CW-1:0]  sc_w, in_x, in_y;
    logic [GW-1:0]  gap_cnt;
    logic [TW-1:0]  drain_cnt;
    logic [WCW-1:0] wr_count;
    logic           rd_en, sc_rst, in_valid;

    logic [CW-1:0]  out_w, out_h;
    logic [WCW-1:0] area, target, wr_prod;
    logic           wr_fire;

    assign out_w  = cur_w >> 1;
    assign out_h  = cur_h >> 1;
    assign area   = WCW'(cur_w) * WCW'(cur_h);
    assign target = WCW'(out_w) * WCW'(out_h);

    // Writeback is a pure pass-through of the scaler output, silenced
    // only while reset is held so an abort stops memory traffic at once.
    assign wr_fire = bus.sc_out_valid & reset;
    assign wr_prod = WCW'(bus.sc_out_y) * WCW'(out_w);

    assign bus.mem_wr_en   = wr_fire;
    assign bus.mem_wr_addr = wr_fire ?
        dst_base + AW'(wr_prod) + AW'(bus.sc_out_x) : '0;
    assign bus.mem_wr_data = wr_fire ? bus.sc_out_pixel : '0;

    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.sc_reset    = sc_rst;
    assign bus.sc_width    = sc_w;
    assign bus.sc_in_valid = in_valid;
    assign bus.sc_in_x     = in_x;
    assign bus.sc_in_y     = in_y;
    // Read data lands exactly in the cycle the delayed valid is high.
    assign bus.sc_in_pixel = in_valid ? bus.mem_rd_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            levels_done <= '0;
            cur_base    <= '0;
            dst_base    <= '0;
            row_addr    <= '0;
            rd_addr     <= '0;
            cur_w       <= '0;
            cur_h       <= '0;
            x           <= '0;
            y           <= '0;
            rd_x        <= '0;
            rd_y        <= '0;
            sc_w        <= '0;
            in_x        <= '0;
            in_y        <= '0;
            gap_cnt     <= '0;
            drain_cnt   <= '0;
            wr_count    <= '0;
            rd_en       <= 1'b0;
            sc_rst      <= 1'b0;
            in_valid    <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_en    <= 1'b0;
            sc_rst   <= 1'b0;
            in_valid <= rd_en;
            in_x     <= rd_x;
            in_y     <= rd_y;
            if (wr_fire) wr_count <= wr_count + 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur_base    <= src_base;
                        cur_w       <= src_width;
                        cur_h       <= src_height;
                        error       <= 1'b0;
                        levels_done <= '0;
                        busy        <= 1'b1;
                        if ((src_width >> 1) == '0 ||
                            (src_height >> 1) == '0)
                            state <= DONE;
                        else
                            state <= SC_RST;
                    end
                end
                SC_RST: begin
                    sc_rst   <= 1'b1;
                    sc_w     <= cur_w;
                    dst_base <= cur_base + AW'(area);
                    row_addr <= cur_base;
                    x        <= '0;
                    y        <= '0;
                    rd_x     <= '0;
                    rd_y     <= '0;
                    wr_count <= '0;
                    state    <= STREAM;
                end
                STREAM: begin
                    rd_en   <= 1'b1;
                    rd_addr <= row_addr + AW'(x);
                    rd_x    <= x;
                    rd_y    <= y;
                    x       <= x + 1'b1;
                    if (x == cur_w - 1'b1) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // Coordinates keep advancing so the scaler sees
                    // the row end and flushes.
                    rd_x <= x;
                    x    <= x + 1'b1;
                    if (gap_cnt == GW'(ROW_GAP - 1)) begin
                        if (y == cur_h - 1'b1) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            x        <= '0;
                            y        <= y + 1'b1;
                            row_addr <= row_addr + AW'(cur_w);
                            state    <= STREAM;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (wr_count == target) begin
                        state <= NEXT;
                    end else if (drain_cnt == TW'(DRAIN_TIMEOUT - 1)) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    levels_done <= levels_done + 3'd1;
                    cur_base    <= dst_base;
                    cur_w       <= out_w;
                    cur_h       <= out_h;
                    if (levels_done + 3'd1 == 3'(MAX_LEVELS) ||
                        (out_w >> 1) == '0 || (out_h >> 1) == '0)
                        state <= DONE;
                    else
                        state <= SC_RST;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PYRAMID_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles        <= '0;
            perf_stream_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles        <= '0;
            perf_stream_cycles <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 1'b1;
            if (in_valid) perf_stream_cycles <= perf_stream_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pyramid_scale_sequencer.sv
// Self-checking bench: frame memory + 2x2 averaging scaler stub around
// the sequencer, compared against a raster-level pyramid model.
module tb_pyramid_scale_sequencer;
    localparam int LB = 8;
    localparam int CB = 16;
    localparam int AB = 20;
    localparam int MEMSZ = 4096;
    localparam int MAXL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AB-1:0] src_base = '0;
    logic [CB-1:0] src_width = '0;
    logic [CB-1:0] src_height = '0;
    logic          busy, done, error;
    logic [2:0]    levels_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [MEMSZ];
    logic [7:0] ref_mem [MEMSZ];
    logic       mem_clr = 1'b0;
    logic       ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       drop = 1'b0;
    logic [7:0] line_buf [2][64];

    int lv_base [8];
    int lv_w [8];
    int lv_h [8];

    always #5 clk = ~clk;

    pyramid_scale_sequencer_if #(
        .LUMA_BITS(LB), .COORD_BITS(CB), .ADDR_BITS(AB)
    ) bus ();

    pyramid_scale_sequencer #(
        .LUMA_BITS(LB), .COORD_BITS(CB), .ADDR_BITS(AB),
        .MAX_LEVELS(MAXL), .ROW_GAP(6), .DRAIN_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_base(src_base), .src_width(src_width),
        .src_height(src_height), .busy(busy), .done(done),
        .error(error), .levels_done(levels_done), .bus(bus)
    );

    function automatic logic [7:0] avg4(input int a, b, c, d);
        return 8'((a + b + c + d + 2) >> 2);
    endfunction

    // Frame memory: 1-cycle read latency, plus a bench load port.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] <= 8'h00;
        end else begin
            if (ld_en) mem[ld_addr] <= ld_data;
            if (bus.mem_wr_en) mem[bus.mem_wr_addr[11:0]] <= bus.mem_wr_data;
        end
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[11:0]];
    end

    // Scaler stub: 2x2 box average emitted one cycle after the
    // bottom-right pixel of each block.
    always @(posedge clk) begin
        bus.sc_out_valid <= 1'b0;
        if (bus.sc_in_valid) begin
            line_buf[bus.sc_in_y[0]][bus.sc_in_x[5:0]] <= bus.sc_in_pixel;
            if (bus.sc_in_x[0] && bus.sc_in_y[0] && !drop) begin
                bus.sc_out_valid <= 1'b1;
                bus.sc_out_x <= bus.sc_in_x >> 1;
                bus.sc_out_y <= bus.sc_in_y >> 1;
                bus.sc_out_pixel <= avg4(
                    int'(line_buf[0][bus.sc_in_x[5:0] - 6'd1]),
                    int'(line_buf[0][bus.sc_in_x[5:0]]),
                    int'(line_buf[1][bus.sc_in_x[5:0] - 6'd1]),
                    int'(bus.sc_in_pixel));
            end
        end
    end

    task automatic load_frame(input int base, input int w, input int h,
                              input int mode);
        @(negedge clk);
        mem_clr = 1'b1;
        @(negedge clk);
        mem_clr = 1'b0;
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'h00;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                logic [7:0] v;
                v = (mode == 1) ? 8'(yy * w + xx) : 8'($urandom_range(0, 255));
                ld_en = 1'b1;
                ld_addr = 12'(base + yy * w + xx);
                ld_data = v;
                ref_mem[base + yy * w + xx] = v;
                @(negedge clk);
            end
        end
        ld_en = 1'b0;
    endtask

    task automatic model_run(input int base, input int w, input int h,
                             output int nlev, output int nout,
                             output int nrd);
        nlev = 0;
        nout = 0;
        nrd = 0;
        while (nlev < MAXL && w / 2 > 0 && h / 2 > 0) begin
            int dst, ow, oh;
            dst = base + w * h;
            ow = w / 2;
            oh = h / 2;
            for (int j = 0; j < oh; j++)
                for (int i = 0; i < ow; i++)
                    ref_mem[dst + j * ow + i] = avg4(
                        int'(ref_mem[base + 2 * j * w + 2 * i]),
                        int'(ref_mem[base + 2 * j * w + 2 * i + 1]),
                        int'(ref_mem[base + (2 * j + 1) * w + 2 * i]),
                        int'(ref_mem[base + (2 * j + 1) * w + 2 * i + 1]));
            lv_base[nlev] = dst;
            lv_w[nlev] = ow;
            lv_h[nlev] = oh;
            nlev++;
            nout += ow * oh;
            nrd += w * h;
            base = dst;
            w = ow;
            h = oh;
        end
    endtask

    task automatic run_seq(input int base, input int w, input int h,
                           input bit restart, output int ndone,
                           output int nrd, output int nwr,
                           output int done_at, output bit err_at_start,
                           output bit busy_at_start);
        int tail;
        @(negedge clk);
        src_base = AB'(base);
        src_width = CB'(w);
        src_height = CB'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        err_at_start = error;
        busy_at_start = busy;
        ndone = 0;
        nrd = 0;
        nwr = 0;
        done_at = -1;
        tail = -1;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) nrd++;
            if (bus.mem_wr_en) nwr++;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c;
                    tail = c + 6;
                end
            end
            if (tail >= 0 && c >= tail) break;
            start = 1'b0;
            if (restart && c == 20) begin
                src_base = AB'(3000);
                src_width = CB'(2);
                src_height = CB'(2);
                start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_frame(input string name, input int base,
                              input int w, input int h, input int mode,
                              input bit restart);
        int nlev, nout, mrd, ndone, nrd, nwr, done_at, bad;
        bit eas, bas;
        load_frame(base, w, h, mode);
        model_run(base, w, h, nlev, nout, mrd);
        run_seq(base, w, h, restart, ndone, nrd, nwr, done_at, eas, bas);
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL %s timeout: no done within cycle budget", name);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", name, ndone);
        end
        checks++;
        if (levels_done !== 3'(nlev)) begin
            errors++;
            $display("FAIL %s levels_done: got %0d want %0d",
                     name, levels_done, nlev);
        end
        checks++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s error/busy after done: got %b/%b want 0/0",
                     name, error, busy);
        end
        checks++;
        if (eas !== 1'b0 || bas !== 1'b1) begin
            errors++;
            $display("FAIL %s error/busy after start: got %b/%b want 0/1",
                     name, eas, bas);
        end
        checks++;
        if (nwr !== nout || nrd !== mrd) begin
            errors++;
            $display("FAIL %s writes/reads: got %0d/%0d want %0d/%0d",
                     name, nwr, nrd, nout, mrd);
        end
        for (int l = 0; l < nlev; l++) begin
            bad = 0;
            for (int k = 0; k < lv_w[l] * lv_h[l]; k++)
                if (mem[lv_base[l] + k] !== ref_mem[lv_base[l] + k]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s level%0d @%0d (%0dx%0d): %0d bad pixels want 0",
                         name, l + 1, lv_base[l], lv_w[l], lv_h[l], bad);
            end
        end
        bad = 0;
        for (int i = 0; i < MEMSZ; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s whole_mem: %0d words differ want 0", name, bad);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({busy, done, error, levels_done,
                     bus.mem_rd_en, bus.mem_rd_addr,
                     bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data,
                     bus.sc_reset, bus.sc_width, bus.sc_in_pixel,
                     bus.sc_in_valid, bus.sc_in_x, bus.sc_in_y});
    endfunction

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h want 0", out_vec());
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0", out_vec());
        end
    endtask

    task automatic test_degenerate();
        int ndone, nrd, nwr, done_at;
        bit eas, bas;
        run_seq(100, 1, 8, 1'b0, ndone, nrd, nwr, done_at, eas, bas);
        checks++;
        if (done_at !== 0 || ndone !== 1) begin
            errors++;
            $display("FAIL degenerate_done: at %0d count %0d want at 0 count 1",
                     done_at, ndone);
        end
        checks++;
        if (nrd !== 0 || nwr !== 0 || levels_done !== 3'd0) begin
            errors++;
            $display("FAIL degenerate_traffic: rd %0d wr %0d lv %0d want 0/0/0",
                     nrd, nwr, levels_done);
        end
    endtask

    task automatic test_drain_timeout();
        int ndone, nrd, nwr, done_at, lo;
        bit eas, bas;
        drop = 1'b1;
        load_frame(0, 8, 4, 0);
        run_seq(0, 8, 4, 1'b0, ndone, nrd, nwr, done_at, eas, bas);
        drop = 1'b0;
        lo = 4 * (8 + 6) + 64;
        checks++;
        if (error !== 1'b1 || ndone !== 1 || levels_done !== 3'd0) begin
            errors++;
            $display("FAIL timeout_status: err %b done %0d lv %0d want 1/1/0",
                     error, ndone, levels_done);
        end
        checks++;
        if (done_at < lo || done_at > lo + 4) begin
            errors++;
            $display("FAIL timeout_latency: done at %0d want %0d..%0d",
                     done_at, lo, lo + 4);
        end
        checks++;
        if (nwr !== 0 || nrd !== 32) begin
            errors++;
            $display("FAIL timeout_traffic: wr %0d rd %0d want 0/32", nwr, nrd);
        end
    endtask

    task automatic test_mid_reset();
        bit hit;
        int bad_acc;
        load_frame(0, 32, 32, 0);
        @(negedge clk);
        src_base = '0;
        src_width = CB'(32);
        src_height = CB'(32);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (levels_done == 3'd1 && bus.mem_rd_en) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midreset_reach: level 2 streaming never seen");
        end
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_vec() !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h want 0", out_vec());
        end
        bad_acc = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_rd_en || bus.mem_wr_en || busy) bad_acc++;
        end
        checks++;
        if (bad_acc != 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d active cycles want 0", bad_acc);
        end
        reset = 1'b1;
        test_frame("after_reset", 0, 32, 32, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame("frame8x4", 0, 8, 4, 0, 1'b0);
        test_frame("ramp16", 0, 16, 16, 1, 1'b0);
        test_frame("odd9x5", 0, 9, 5, 0, 1'b0);
        test_frame("cap32", 0, 32, 32, 0, 1'b0);
        test_frame("offset_base", 517, 12, 10, 0, 1'b0);
        test_degenerate();
        test_drain_timeout();
        test_frame("error_clear", 0, 8, 4, 0, 1'b0);
        test_frame("start_while_busy", 64, 16, 8, 0, 1'b1);
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
